serial_bit_feeder: RTL and testbench
====================================

# serial_bit_feeder

Upstream stage for the serial pattern detectors. It accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on the single-bit `x` line that a detector samples every cycle. A one-word holding buffer lets back-to-back words stream with no idle bit between them. Frame-level status (`x_valid`, `word_done`) is provided for counters and monitors placed alongside the detector.

## Interface
- `DATA_W`, default 8: word width in bits. Legal range is 2..32.
- `clk`  in  1  single clock; all state changes occur on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_data`  in  DATA_W  parallel word to serialize.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_ready`  out  1  feeder can accept a word this cycle.
- `x`  out  1  serial bit to the detector. Driven 0 when idle.
- `x_valid`  out  1  `x` carries a frame bit this cycle.
- `word_done`  out  1  high during the cycle the last bit of a frame is on `x`.

## Operation
- **Accept.** A word is accepted on any rising edge where `in_valid && in_ready`.
  - `in_ready = !buf_full`. It depends on registered state only; there is no combinational path from `in_valid`.
- **States.**
  - IDLE: shifter empty.
  - SHIFT: a frame is being emitted.
  - `buf_full` is an independent flag.
- **Load rule, evaluated every edge.** The shifter loads a new word when it is in IDLE, or in SHIFT on the last frame bit.
  - Source is the buffer if `buf_full`; otherwise it is the word being accepted this edge (bypass).
  - If there is no source, the shifter goes to IDLE.
  - An accepted word that does not bypass is written into the buffer.
- **Simultaneous drain and accept.** This case cannot occur: `in_ready` is low whenever `buf_full` is set.
- **Shifter.**
  - Holds the frame in a shift register and a bit counter of width `$clog2(DATA_W+1)+1`.
  - `x` is the shift-register MSB.
  - The register shifts left each cycle while in SHIFT, and the counter counts 0..FRAME_LEN-1.
  - `word_done = (state==SHIFT) && (cnt==FRAME_LEN-1)`.
- **Idle outputs.** `x_valid = (state==SHIFT)`. `x` is forced to 0 when not in SHIFT.
- **Reset.** Asserting `rst_n` low at any time, including mid-frame:
  - State goes to IDLE, `buf_full` to 0, shift register and counter to 0.
  - The in-flight word and the buffered word are discarded.
  - Output values during reset: `x=0`, `x_valid=0`, `word_done=0`, `in_ready=1`.

## Timing
- **Latency.** For a word accepted at edge k into an empty feeder, its MSB is on `x` in the cycle after edge k. The last bit appears after edge k+FRAME_LEN-1.
- **Frame length.** FRAME_LEN = `DATA_W`, or `DATA_W+1` with parity enabled (see Configuration).
- **Throughput.** One bit per cycle. A continuously valid source gets gap-free frames, and `x_valid` stays high across word boundaries.
- **`in_ready` pattern during streaming.**
  - `in_ready` drops the cycle after a word is buffered.
  - It rises the cycle after the buffered word moves into the shifter, which is the cycle after `word_done`.
- **Bypass case.** A word accepted during the last bit of a frame bypasses the buffer: its MSB follows the previous LSB in the very next cycle.
- **Reset release.** The feeder accepts on the first rising edge after `rst_n` is deasserted.

## Configuration
- **`SER_PARITY_EN` defined:**
  - Each frame gets one even-parity bit appended after the LSB. That bit is the XOR of all data bits.
  - FRAME_LEN = `DATA_W+1`, and `word_done` coincides with the parity bit.
- **`SER_PARITY_EN` undefined:**
  - No parity logic is present.
  - FRAME_LEN = `DATA_W`, and `word_done` coincides with the LSB.

## Test plan
1. **Reset values.** Hold `rst_n`=0 while driving random `in_valid`/`in_data` -> `x=0`, `x_valid=0`, `word_done=0`, `in_ready=1` throughout; nothing is accepted.
2. **Single word.** `DATA_W`=8, no parity. Accept 8'hA5 at edge k -> `x`=1,0,1,0,0,1,0,1 in cycles k+1..k+8. `x_valid`=1 for exactly those 8 cycles. `word_done`=1 only in cycle k+8. Then `x=0`, `x_valid=0`.
3. **Back-to-back.** Hold `in_valid`=1 with 8'h05 then 8'hFF -> 16 consecutive valid bits 00000101_11111111 with no gap. `in_ready`=0 while the second word is buffered. `word_done` pulses at bit 8 and bit 16.
4. **Reset mid-frame.** Assert `rst_n`=0 after 3 bits of 8'hF0, with 8'h0F buffered -> all outputs go to reset values immediately and the buffer empties. A new word 8'h81 after release emits cleanly as 1,0,0,0,0,0,0,1.
5. **Parity.** With `SER_PARITY_EN`, accept 8'h07 -> 9 bits 0,0,0,0,0,1,1,1,1. `word_done` on the 9th bit. 8'h03 ends with parity bit 0.
6. **Detector chain.** Connect `x` to the 101 detector, no parity, and send 8'h50 -> `x`=0,1,0,1,0,0,0,0. The detector output `y` is asserted exactly once, in the cycle after the 4th bit is sampled.

Source files
------------

// File: rtl/serial_bit_feeder_if.sv
// Handshake and serial-output bundle for serial_bit_feeder.
// The slave modport is the feeder side; the master modport is the word source / monitor side.
interface serial_bit_feeder_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              x;
  logic              x_valid;
  logic              word_done;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  x,
    input  x_valid,
    input  word_done
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output x,
    output x_valid,
    output word_done
  );
endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: MSB-first, one bit per clock, with a one-word holding buffer.
// Optional feature: define SER_PARITY_EN to append an even-parity bit after each word's LSB.
module serial_bit_feeder #(
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_bit_feeder_if.slave   bus
);

`ifdef SER_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif
  localparam int CNT_W = $clog2(DATA_W + 1) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [FRAME_LEN-1:0] r_shreg;
  logic [DATA_W-1:0]    r_buf;
  logic                 r_buf_full;

  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_load_slot;
  logic                 w_bypass;
  logic                 w_load_buf;

  function automatic logic [FRAME_LEN-1:0] makeFrame(input logic [DATA_W-1:0] word);
`ifdef SER_PARITY_EN
    return {word, ^word};
`else
    return word;
`endif
  endfunction

  // Ready is purely registered, so the buffer can never be drained and refilled on one edge.
  assign w_in_ready  = !r_buf_full;
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_last      = (r_state == ST_SHIFT) && (r_cnt == LAST_CNT);
  assign w_load_slot = (r_state == ST_IDLE) || w_last;
  assign w_bypass    = w_load_slot && !r_buf_full && w_accept;
  assign w_load_buf  = w_load_slot && r_buf_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
    end else if (w_load_buf) begin
      r_buf_full <= 1'b0;
    end else if (w_accept && !w_bypass) begin
      r_buf      <= bus.in_data;
      r_buf_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
    end else if (w_load_buf) begin
      r_state <= ST_SHIFT;
      r_cnt   <= '0;
      r_shreg <= makeFrame(r_buf);
    end else if (w_bypass) begin
      r_state <= ST_SHIFT;
      r_cnt   <= '0;
      r_shreg <= makeFrame(bus.in_data);
    end else if (w_load_slot) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
      r_shreg <= r_shreg << 1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.x         = (r_state == ST_SHIFT) ? r_shreg[FRAME_LEN-1] : 1'b0;
  assign bus.x_valid   = (r_state == ST_SHIFT);
  assign bus.word_done = w_last;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Self-checking bench for serial_bit_feeder: queue-based reference model plus directed literal checks.
module tb_serial_bit_feeder;

`ifdef SER_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  serial_bit_feeder_if #(.DATA_W(8)) bus ();

  serial_bit_feeder #(.DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: frameQ holds the bits still to appear on x (head is current), pendQ the held word.
  bit         frameQ[$];
  logic [7:0] pendQ[$];
  bit         mAcc;

  task automatic pushFrame(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) frameQ.push_back(w[i]);
`ifdef SER_PARITY_EN
    frameQ.push_back(^w);
`endif
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frameQ.delete();
      pendQ.delete();
    end else begin
      mAcc = bus.in_valid && (pendQ.size() == 0);
      if (frameQ.size() > 0) void'(frameQ.pop_front());
      if (frameQ.size() == 0) begin
        if (pendQ.size() > 0) pushFrame(pendQ.pop_front());
        else if (mAcc) begin
          pushFrame(bus.in_data);
          mAcc = 1'b0;
        end
      end
      if (mAcc) pendQ.push_back(bus.in_data);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("x", 32'(bus.x), (frameQ.size() > 0) ? 32'(frameQ[0]) : 32'd0);
    checkOutput("x_valid", 32'(bus.x_valid), 32'(frameQ.size() > 0));
    checkOutput("word_done", 32'(bus.word_done), 32'(frameQ.size() == 1));
    checkOutput("in_ready", 32'(bus.in_ready), 32'(pendQ.size() == 0));
  end

  task automatic applyStimulus(input logic v, input logic [7:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
  endtask

  // Sends one word into an idle feeder and records n bits of x and word_done, MSB of the mask first.
  task automatic sendAndCapture(input logic [7:0] w, input int n,
                                output logic [31:0] bits, output logic [31:0] done);
    bits = '0;
    done = '0;
    applyStimulus(1'b1, w);
    @(posedge clk);
    #1 applyStimulus(1'b0, 8'h00);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bits[n-1-i] = bus.x;
      done[n-1-i] = bus.word_done;
    end
    @(negedge clk);
    checkOutput("idle_after_frame", 32'(bus.x_valid), 32'd0);
  endtask

  logic [31:0] capBits;
  logic [31:0] capDone;
  logic [15:0] b2bExp;
  int          hits;
  int          hitPos;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    applyStimulus(1'b0, 8'h00);

    // Reset held with random traffic: compare process expects idle outputs and ready=1.
    repeat (10) begin
      @(posedge clk);
      #1 applyStimulus(1'($urandom_range(0, 1)), 8'($urandom));
    end
    @(negedge clk);
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
    applyStimulus(1'b0, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

`ifndef SER_PARITY_EN
    sendAndCapture(8'hA5, 8, capBits, capDone);
    checkOutput("single_bits", capBits, 32'h0000_00A5);
    checkOutput("single_done", capDone, 32'h0000_0001);

    // Back-to-back: second word is buffered while the first is still shifting.
    b2bExp = 16'h05FF;
    applyStimulus(1'b1, 8'h05);
    @(posedge clk);
    #1 applyStimulus(1'b1, 8'hFF);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checkOutput("b2b_x", 32'(bus.x), 32'(b2bExp[15-i]));
      checkOutput("b2b_valid", 32'(bus.x_valid), 32'd1);
      checkOutput("b2b_done", 32'(bus.word_done), 32'(i == 7 || i == 15));
      checkOutput("b2b_ready", 32'(bus.in_ready), 32'(!(i >= 1 && i <= 7)));
      if (i == 0) begin
        @(posedge clk);
        #1 applyStimulus(1'b0, 8'h00);
      end
    end
    @(negedge clk);

    // Reset mid-frame with a word held in the buffer.
    applyStimulus(1'b1, 8'hF0);
    @(posedge clk);
    #1 applyStimulus(1'b1, 8'h0F);
    @(posedge clk);
    #1 applyStimulus(1'b0, 8'h00);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_x", 32'(bus.x), 32'd0);
    checkOutput("midrst_valid", 32'(bus.x_valid), 32'd0);
    checkOutput("midrst_done", 32'(bus.word_done), 32'd0);
    checkOutput("midrst_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sendAndCapture(8'h81, 8, capBits, capDone);
    checkOutput("post_rst_bits", capBits, 32'h0000_0081);
    checkOutput("post_rst_done", capDone, 32'h0000_0001);

    // Stream for a 101 detector: exactly one overlapping hit, ending on the 4th bit.
    sendAndCapture(8'h50, 8, capBits, capDone);
    checkOutput("det_bits", capBits, 32'h0000_0050);
    hits   = 0;
    hitPos = -1;
    for (int i = 2; i < 8; i++) begin
      if (capBits[9-i] && !capBits[8-i] && capBits[7-i]) begin
        hits++;
        hitPos = i;
      end
    end
    checkOutput("det_hits", 32'(hits), 32'd1);
    checkOutput("det_pos", 32'(hitPos), 32'd3);
`else
    sendAndCapture(8'h07, 9, capBits, capDone);
    checkOutput("par07_bits", capBits, 32'h0000_000F);
    checkOutput("par07_done", capDone, 32'h0000_0001);
    sendAndCapture(8'h03, 9, capBits, capDone);
    checkOutput("par03_bits", capBits, 32'h0000_0006);
    checkOutput("par03_parity", 32'(capBits[0]), 32'd0);
`endif

    // Randomized traffic with occasional resets; the compare process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      rst_n = ($urandom_range(0, 399) != 0);
      applyStimulus(1'($urandom_range(0, 99) < 70), 8'($urandom));
    end
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00);
    repeat (2 * FL + 4) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
